// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared fan FSM states, level encodings, default duties and LED map
`timescale 1ns/1ps
package fan_pkg;

  typedef enum logic [1:0] {
    FAN_OFF  = 2'd0,
    FAN_RAMP = 2'd1,
    FAN_RUN  = 2'd2
  } fan_state_e;

  localparam logic [1:0] LVL_OFF = 2'd0;
  localparam logic [1:0] LVL_1   = 2'd1;
  localparam logic [1:0] LVL_2   = 2'd2;
  localparam logic [1:0] LVL_3   = 2'd3;

  localparam logic [7:0] DUTY_L1_DEF = 8'd85;
  localparam logic [7:0] DUTY_L2_DEF = 8'd170;
  localparam logic [7:0] DUTY_L3_DEF = 8'd255;

  localparam logic [2:0] LED_OFF = 3'b000;
  localparam logic [2:0] LED_L1  = 3'b001;
  localparam logic [2:0] LED_L2  = 3'b010;
  localparam logic [2:0] LED_L3  = 3'b100;

  // One-hot front-panel encoding shared with the timer and display blocks.
  function automatic logic [2:0] level_to_led(input logic [1:0] lvl);
    case (lvl)
      LVL_1:   return LED_L1;
      LVL_2:   return LED_L2;
      LVL_3:   return LED_L3;
      default: return LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// rtl/fan_pwm_gen.sv - 8-bit PWM with prescaler, period strobe and boundary-latched duty
`timescale 1ns/1ps
module fan_pwm_gen #(
  parameter int PWM_DIV = 40
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_duty_req,
  output logic       o_boundary,
  output logic [7:0] o_duty,
  output logic       o_pwm
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PWM_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [7:0]    r_pwm_cnt;
  logic [7:0]    r_duty;
  logic          r_pwm;
  logic          w_tick;

  assign w_tick     = (r_pre == PRE_LAST);
  assign o_boundary = w_tick && (r_pwm_cnt == 8'hFF);
  assign o_duty     = r_duty;
  assign o_pwm      = r_pwm;

  // Counters advance every tick; duty only moves at the period boundary so no runt pulse is possible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= 8'd0;
      r_duty    <= 8'd0;
      r_pwm     <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
      if (o_boundary) begin
        r_duty <= i_duty_req;
      end
      r_pwm <= (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);
    end
  end

endmodule

// File: rtl/fan_speed_cntr.sv
// rtl/fan_speed_cntr.sv - fan speed FSM with optional soft-start ramp (macro SOFT_START_EN)
`timescale 1ns/1ps
module fan_speed_cntr
  import fan_pkg::*;
#(
  parameter int         PWM_DIV      = 40,
  parameter int         RAMP_PERIODS = 4,
  parameter logic [7:0] DUTY_L1      = DUTY_L1_DEF,
  parameter logic [7:0] DUTY_L2      = DUTY_L2_DEF,
  parameter logic [7:0] DUTY_L3      = DUTY_L3_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_speed,
  input  logic       btn_off,
  input  logic       timeout,
  output logic       state,
  output logic       pwm_out,
  output logic [7:0] duty,
  output logic [2:0] speed_led
);

  fan_state_e r_fsm;
  fan_state_e w_fsm_nxt;
  logic [1:0] r_level;
  logic [1:0] w_level_nxt;
  logic       r_timeout_q;
  logic       w_stop;
  logic       w_boundary;
  logic [7:0] w_target;
  logic [7:0] w_duty_req;

  // Only a falling edge of timeout stops the fan; a level stuck low never blocks a restart.
  assign w_stop    = btn_off | (r_timeout_q & ~timeout);
  assign state     = (r_fsm != FAN_OFF);
  assign speed_led = level_to_led(r_level);

  // Duty target for the current level.
  always_comb begin
    w_target = 8'd0;
    case (r_level)
      LVL_1:   w_target = DUTY_L1;
      LVL_2:   w_target = DUTY_L2;
      LVL_3:   w_target = DUTY_L3;
      default: w_target = 8'd0;
    endcase
  end

`ifdef SOFT_START_EN
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_PERIODS - 1);
  localparam fan_state_e ENTRY_STATE = FAN_RAMP;

  logic [RW-1:0] r_ramp_cnt;
  logic          w_ramp_step;

  assign w_ramp_step = (r_ramp_cnt == RAMP_LAST);

  // Ramp counter counts period boundaries while ramping; cleared whenever the fan goes off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp_cnt <= '0;
    end else if (w_fsm_nxt == FAN_OFF) begin
      r_ramp_cnt <= '0;
    end else if ((r_fsm == FAN_RAMP) && w_boundary) begin
      r_ramp_cnt <= w_ramp_step ? '0 : r_ramp_cnt + RW'(1);
    end
  end
`else
  localparam fan_state_e ENTRY_STATE = FAN_RUN;

  logic w_unused_boundary;
  assign w_unused_boundary = w_boundary;
`endif

  // Next state, level and the duty offered to the PWM for the next boundary.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_level_nxt = r_level;
    w_duty_req  = duty;
    case (r_fsm)
      FAN_OFF: w_duty_req = 8'd0;
`ifdef SOFT_START_EN
      FAN_RAMP: begin
        if (duty >= w_target) begin
          w_duty_req = w_target;
        end else if (w_ramp_step) begin
          w_duty_req = duty + 8'd1;
        end
        if (w_boundary && (duty == w_target)) begin
          w_fsm_nxt = FAN_RUN;
        end
      end
`endif
      FAN_RUN: w_duty_req = w_target;
      default: begin
        w_fsm_nxt   = FAN_OFF;
        w_level_nxt = LVL_OFF;
        w_duty_req  = 8'd0;
      end
    endcase
    // Level changes take effect now; the new target reaches duty from the following boundary.
    if (w_stop) begin
      w_fsm_nxt   = FAN_OFF;
      w_level_nxt = LVL_OFF;
    end else if (btn_speed) begin
      if (r_level == LVL_3) begin
        w_fsm_nxt   = FAN_OFF;
        w_level_nxt = LVL_OFF;
      end else begin
        w_fsm_nxt   = ENTRY_STATE;
        w_level_nxt = r_level + 2'd1;
      end
    end
  end

  // FSM, level and timeout edge registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= FAN_OFF;
      r_level     <= LVL_OFF;
      r_timeout_q <= 1'b1;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_level     <= w_level_nxt;
      r_timeout_q <= timeout;
    end
  end

  fan_pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_duty_req (w_duty_req),
    .o_boundary (w_boundary),
    .o_duty     (duty),
    .o_pwm      (pwm_out)
  );

endmodule

// File: doc/fan_speed_cntr.md
Name: fan_speed_cntr

Overview:
- Fan motor speed controller sitting beside the fan countdown timer.
- Produces the fan `state` (run) flag that the timer consumes, and consumes the timer's `timeout`.
- Button pulses cycle speed OFF→1→2→3→OFF; a glitch-free 8-bit PWM drives the fan with soft-start ramping.
- Timer expiry (1→0 edge on `timeout`) or the off button stops the fan immediately.

Parameters:
- PWM_DIV, 40: clk cycles per PWM count tick (100 MHz/40/256 ≈ 9.8 kHz PWM).
- RAMP_PERIODS, 4: PWM periods per +1 duty step while ramping.
- DUTY_L1, 85: target duty for level 1.
- DUTY_L2, 170: target duty for level 2.
- DUTY_L3, 255: target duty for level 3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset (one clock; reset is asynchronous and active-low).
- btn_speed  in  1  debounced single-cycle pulse; advance speed level.
- btn_off  in  1  debounced single-cycle pulse; force OFF.
- timeout  in  1  from timer; 1 = running or untimed, 0 = timer expired.
- state  out  1  1 when the FSM is not OFF; feeds the timer's run gate.
- pwm_out  out  1  fan PWM drive.
- duty  out  8  currently applied duty (the boundary-latched value).
- speed_led  out  3  one-hot level: 001 = L1, 010 = L2, 100 = L3; 000 = off.

Behaviour:
- Reset values: state=0, pwm_out=0, duty=0, speed_led=000. FSM=OFF, level=0, all counters 0, timeout edge register=1.
- Prescaler counts 0..PWM_DIV-1. At terminal count, pwm_cnt increments (8-bit, wraps 255→0).
- Period boundary = prescaler terminal AND pwm_cnt==255.
- pwm_out is registered: 1 when duty==255, or when pwm_cnt < duty. It therefore lags the counter by 1 clk.
- `duty` changes only at a period boundary. No runt pulses are allowed.
- Timeout handling: `timeout` is registered once. stop_evt = btn_off | (timeout_q & ~timeout), i.e. a falling edge only. A level stuck at 0 never blocks a restart.
- FSM states: OFF, RAMP, RUN.
  - OFF: level=0, target=0. On btn_speed: level=1 and go to RAMP (RUN if SOFT_START_EN is undefined).
  - RAMP: ramp counter counts period boundaries. Every RAMP_PERIODS boundaries, duty += 1, saturating at target. When duty==target at a boundary, go to RUN.
  - RUN: duty is held at target.
  - In RAMP or RUN, btn_speed advances level 1→2 or 2→3 (new target, go to RAMP) and 3→OFF.
- Entering OFF, from any path: level=0 and speed_led=000 in the same cycle. state falls on the next clk edge. duty is forced to 0 at the next period boundary, with no ramp-down. The ramp counter clears.
- Level increases ramp up from the current duty, never from 0.
- Simultaneous events: stop_evt beats btn_speed. btn_speed and a boundary in the same cycle: the level change applies first, and the new target is used from the following boundary.
- A btn_speed pulse in OFF in the same cycle as a timeout falling edge is ignored (the fan stays OFF).
- Asynchronous reset mid-ramp returns to reset values immediately. pwm_out goes low without waiting for a boundary.

Optional Feature:
- Macro: SOFT_START_EN.
- Defined: RAMP behaviour as above.
- Undefined: RAMP state and ramp counter are not built. Any level change goes straight to RUN, and duty jumps to the target at the next period boundary.
- state, speed_led and stop behaviour are identical in both builds.

Decomposition:
- Shared package fan_pkg: FSM state enum (OFF/RAMP/RUN), level constants, default DUTY_L1..L3, and the one-hot LED encodings. The timer and display blocks use the same level encoding.
- One sub-module, fan_pwm_gen, holds:
  - prescaler, pwm_cnt and period-boundary strobe;
  - boundary-latched duty register;
  - pwm_out comparator.
- The FSM and ramp logic stay in fan_speed_cntr.

Test Plan (bench uses PWM_DIV=1, RAMP_PERIODS=1, SOFT_START_EN defined):
- Reset release, no buttons for 600 clks → state=0, pwm_out=0, duty=0, speed_led=000.
- One btn_speed pulse → state=1 on the next clk, speed_led=001. duty rises 1 per 256-clk period to 85, then FSM=RUN; pwm_out high for exactly 85 of every 256 clks.
- In RUN at L1, btn_speed twice (L2, then L3 after settling) → duty ramps 85→170→255, with no reset to 0 between. At 255, pwm_out is constantly 1.
- At L2, drive timeout 1→0 → state=0 within 1 clk, duty=0 at the next boundary. With timeout held at 0, a later btn_speed restarts to L1.
- btn_off and btn_speed in the same cycle while at L1 → OFF; level stays 0.
- Assert reset_n low mid-ramp at duty=40 → pwm_out=0 and duty=0 asynchronously. Rebuild with SOFT_START_EN undefined: btn_speed → duty=85 at the first boundary, FSM=RUN directly.
